bmu_wb_buffer: RTL

//  Downstream stage of the BMU: collects each registered BMU result (resultFf/error)
//  at the right cycle, pairs it with the destination tag issued alongside the op,
//  and queues it in a small FIFO.

---
 rtl/bmu_wb_buffer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bmu_wb_buffer.sv
// bmu_wb_buffer
//   Writeback stage behind the BMU. Each issued op's destination tag travels
//   through a LAT-deep shift pipe next to the BMU. When the tag leaves the
//   last stage, it is paired with the BMU's registered result and error flag.
//   The resulting entry is queued in a DEPTH-entry FIFO. The FIFO drains over
//   a valid/ready handshake.
//
//   Optional feature: define BMU_WB_ERRCNT_EN to build a saturating counter of
//   captured error results. When it is not defined, errCount is tied to zero.
//
// Ports
//   clk, rstL        clock; asynchronous active-low reset
//   flush            drop all queued and in-flight results (synchronous)
//   validIn, tagIn   op issued to the BMU this cycle, and its destination tag
//   resultFf, error  BMU registered result and error flag (valid when cap=1)
//   stallOut         issue side must not assert validIn next cycle
//   wbValid/wbReady  writeback handshake for the FIFO head
//   wbData/wbTag/wbError  head entry fields (0 when the FIFO is empty)
//   overflow         sticky: a result was dropped because the FIFO was full
//   errCount         count of captured error results
module bmu_wb_buffer #(
   parameter int LAT   = 1,
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rstL,
   input  logic             flush,
   input  logic             validIn,
   input  logic [TAG_W-1:0] tagIn,
   input  logic [31:0]      resultFf,
   input  logic             error,
   output logic             stallOut,
   output logic             wbValid,
   input  logic             wbReady,
   output logic [31:0]      wbData,
   output logic [TAG_W-1:0] wbTag,
   output logic             wbError,
   output logic             overflow,
   output logic [15:0]      errCount
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [31:0]      data;
      logic             err;
      logic [TAG_W-1:0] tag;
   } entry_t;

   // tag pipe: stage i holds the op issued i cycles ago
   logic [LAT:1]            vld_pipe;
   logic [LAT:1][TAG_W-1:0] tag_pipe;
   logic                    cap;

   entry_t      mem [DEPTH];
   entry_t      head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, push, pop, drop;
   logic [31:0]   in_flight;

   assign cap = vld_pipe[LAT];

   // flush has priority: no push, pop or drop happens in a flush cycle
   assign wbValid = (count != '0);
   assign full    = (count == FULL_CNT);
   assign pop     = wbValid & wbReady & ~flush;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign push    = cap & ~flush & (~full | pop);
   assign drop    = cap & ~flush & full & ~pop;

   always_comb begin
      in_flight = '0;
      for (int i = 1; i <= LAT; i++)
         in_flight = in_flight + 32'(vld_pipe[i]);
   end

   // credit check: queued + in flight + the op being issued now must fit
   assign stallOut = (32'(count) + in_flight + 32'(validIn)) >= 32'(DEPTH);

   // unwritten slots are never visible because the head is masked when empty
   assign head    = mem[rd_ptr];
   assign wbData  = wbValid ? head.data : '0;
   assign wbTag   = wbValid ? head.tag  : '0;
   assign wbError = wbValid ? head.err  : 1'b0;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {resultFf, error, tag_pipe[LAT]};
   end

   always_ff @(posedge clk or negedge rstL) begin
      if (!rstL) begin
         vld_pipe <= '0;
         tag_pipe <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         vld_pipe[1] <= validIn & ~flush;
         tag_pipe[1] <= tagIn;
         for (int i = 2; i <= LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1] & ~flush;
            tag_pipe[i] <= tag_pipe[i-1];
         end
         if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
            if (drop) overflow <= 1'b1;
         end
      end
   end

`ifdef BMU_WB_ERRCNT_EN
   logic [15:0] err_cnt;

   // saturating; survives flush, cleared only by reset
   always_ff @(posedge clk or negedge rstL) begin
      if (!rstL)
         err_cnt <= '0;
      else if (push && error && err_cnt != 16'hFFFF)
         err_cnt <= err_cnt + 16'd1;
   end

   assign errCount = err_cnt;
`else
   assign errCount = 16'h0000;
`endif

endmodule
